// File: rtl/pcpi_seq_div.sv
`default_nettype none
// ============================================================================
//  Module      : pcpi_seq_div
//  Description : Iterative RV32M DIV/DIVU/REM/REMU coprocessor on the PCPI
//                bus. Restoring shift-subtract divider resolving
//                BITS_PER_CYCLE quotient bits per busy cycle (1, 2 or 4).
//  Revision    : 1.0 - initial release
// ============================================================================
module pcpi_seq_div #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        pcpi_valid,
    input  logic [31:0] pcpi_insn,
    input  logic [31:0] pcpi_rs1,
    input  logic [31:0] pcpi_rs2,
    output logic        pcpi_wr,
    output logic [31:0] pcpi_rd,
    output logic        pcpi_wait,
    output logic        pcpi_ready
);

    // Number of busy cycles needed to resolve all 32 quotient bits
    localparam int         C_NUM_ITER = 32 / BITS_PER_CYCLE;
    localparam logic [4:0] C_CNT_LOAD = 5'(C_NUM_ITER - 1);

    // FSM encoding
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [4:0]  r_cnt;
    logic        r_is_rem;     // REM/REMU selects the remainder
    logic        r_q_neg;      // negate quotient (DIV only)
    logic        r_r_neg;      // negate remainder (REM only)
    logic        r_div0;       // divisor was zero
    logic [31:0] r_divisor;    // |rs2| or raw rs2
    logic [31:0] r_rem;        // partial remainder
    logic [31:0] r_quo;        // dividend bits shifting out, quotient bits in

    logic        r_wr;
    logic [31:0] r_rd;
    logic        r_wait;
    logic        r_ready;

    // ------------------------------------------------------------------------
    // Instruction decode
    // ------------------------------------------------------------------------
    logic        w_match;
    logic        w_signed;
    logic        w_is_rem;
    logic        w_is_div_s;
    logic        w_is_rem_s;
    logic [31:0] w_abs_rs1;
    logic [31:0] w_abs_rs2;
    logic        w_unused_insn;

    assign w_match    = (pcpi_insn[6:0]   == 7'b0110011) &&
                        (pcpi_insn[31:25] == 7'b0000001) &&
                        pcpi_insn[14];
    // funct3[0] clear means a signed operation (DIV/REM)
    assign w_signed   = ~pcpi_insn[12];
    assign w_is_rem   = pcpi_insn[13];
    assign w_is_div_s = ~pcpi_insn[13] & ~pcpi_insn[12];
    assign w_is_rem_s =  pcpi_insn[13] & ~pcpi_insn[12];

    // 32-bit absolute value: |0x80000000| wraps back to 0x80000000, which the
    // unsigned datapath then treats as 2^31, exactly as required
    assign w_abs_rs1 = (w_signed && pcpi_rs1[31]) ? (32'd0 - pcpi_rs1) : pcpi_rs1;
    assign w_abs_rs2 = (w_signed && pcpi_rs2[31]) ? (32'd0 - pcpi_rs2) : pcpi_rs2;

    // Register fields are irrelevant to the coprocessor
    assign w_unused_insn = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

    // ------------------------------------------------------------------------
    // Unrolled restoring steps: BITS_PER_CYCLE steps chained per busy cycle
    // ------------------------------------------------------------------------
    logic [31:0] w_rem_st [0:BITS_PER_CYCLE];
    logic [31:0] w_quo_st [0:BITS_PER_CYCLE];

    assign w_rem_st[0] = r_rem;
    assign w_quo_st[0] = r_quo;

    for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
        logic [32:0] w_shift;
        logic [33:0] w_trial;

        // 33-bit partial remainder with the next dividend bit shifted in
        assign w_shift = {w_rem_st[gi], w_quo_st[gi][31]};
        assign w_trial = {1'b0, w_shift} - {2'b00, r_divisor};

        // A negative trial restores the shifted value. The restored value is
        // below the divisor, so its top bit is always zero and 32 bits suffice.
        assign w_rem_st[gi+1] = w_trial[33] ? w_shift[31:0] : w_trial[31:0];
        assign w_quo_st[gi+1] = {w_quo_st[gi][30:0], ~w_trial[33]};
    end

    // ------------------------------------------------------------------------
    // Final result selection (valid in the last busy cycle)
    // ------------------------------------------------------------------------
    logic [31:0] w_quo_fin;
    logic [31:0] w_rem_fin;
    logic [31:0] w_result;

    assign w_quo_fin = w_quo_st[BITS_PER_CYCLE];
    assign w_rem_fin = w_rem_st[BITS_PER_CYCLE];

    // Divide-by-zero yields an all-ones quotient from the datapath; the sign
    // fix-up is suppressed so DIV by zero also returns 0xFFFFFFFF.
    always_comb begin
        w_result = 32'd0;
        if (r_is_rem) begin
            w_result = r_r_neg ? (32'd0 - w_rem_fin) : w_rem_fin;
        end else begin
            w_result = (r_q_neg && !r_div0) ? (32'd0 - w_quo_fin) : w_quo_fin;
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM, operand capture, iteration and registered outputs
    // ------------------------------------------------------------------------
    // Sequences IDLE->BUSY->DONE, advances the divider and drives the handshake
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_cnt     <= 5'd0;
            r_is_rem  <= 1'b0;
            r_q_neg   <= 1'b0;
            r_r_neg   <= 1'b0;
            r_div0    <= 1'b0;
            r_divisor <= 32'd0;
            r_rem     <= 32'd0;
            r_quo     <= 32'd0;
            r_wr      <= 1'b0;
            r_rd      <= 32'd0;
            r_wait    <= 1'b0;
            r_ready   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_wr    <= 1'b0;
                    r_ready <= 1'b0;
                    r_rd    <= 32'd0;
                    if (pcpi_valid && w_match) begin
                        r_state   <= S_BUSY;
                        r_wait    <= 1'b1;
                        r_cnt     <= C_CNT_LOAD;
                        r_is_rem  <= w_is_rem;
                        r_q_neg   <= w_is_div_s & (pcpi_rs1[31] ^ pcpi_rs2[31]);
                        r_r_neg   <= w_is_rem_s & pcpi_rs1[31];
                        r_div0    <= (pcpi_rs2 == 32'd0);
                        r_divisor <= w_abs_rs2;
                        r_rem     <= 32'd0;
                        r_quo     <= w_abs_rs1;
                    end else begin
                        r_wait <= 1'b0;
                    end
                end

                S_BUSY: begin
                    if (!pcpi_valid) begin
                        // Master withdrew the request: discard everything,
                        // including on the final iteration
                        r_state <= S_IDLE;
                        r_wait  <= 1'b0;
                        r_wr    <= 1'b0;
                        r_ready <= 1'b0;
                        r_rd    <= 32'd0;
                    end else begin
                        r_rem <= w_rem_fin;
                        r_quo <= w_quo_fin;
                        r_cnt <= r_cnt - 5'd1;
                        if (r_cnt == 5'd0) begin
                            r_state <= S_DONE;
                            r_wait  <= 1'b0;
                            r_wr    <= 1'b1;
                            r_ready <= 1'b1;
                            r_rd    <= w_result;
                        end
                    end
                end

                S_DONE: begin
                    // One-cycle result pulse; no request accepted here
                    r_state <= S_IDLE;
                    r_wr    <= 1'b0;
                    r_ready <= 1'b0;
                    r_rd    <= 32'd0;
                    r_wait  <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_wr    <= 1'b0;
                    r_ready <= 1'b0;
                    r_rd    <= 32'd0;
                    r_wait  <= 1'b0;
                end
            endcase
        end
    end

    assign pcpi_wr    = r_wr;
    assign pcpi_rd    = r_rd;
    assign pcpi_wait  = r_wait;
    assign pcpi_ready = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_pcpi_seq_div.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pcpi_seq_div
//  Description : Directed self-checking bench for pcpi_seq_div, one instance
//                at one bit per cycle and one at four bits per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pcpi_seq_div;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    logic        clk;
    logic        resetn;
    logic        valid_a;
    logic        valid_b;
    logic [31:0] insn;
    logic [31:0] rs1;
    logic [31:0] rs2;

    logic        wr_a, wait_a, ready_a;
    logic [31:0] rd_a;
    logic        wr_b, wait_b, ready_b;
    logic [31:0] rd_b;

    int checks;
    int errors;

    pcpi_seq_div #(.BITS_PER_CYCLE(1)) dut_a (
        .clk        (clk),
        .resetn     (resetn),
        .pcpi_valid (valid_a),
        .pcpi_insn  (insn),
        .pcpi_rs1   (rs1),
        .pcpi_rs2   (rs2),
        .pcpi_wr    (wr_a),
        .pcpi_rd    (rd_a),
        .pcpi_wait  (wait_a),
        .pcpi_ready (ready_a)
    );

    pcpi_seq_div #(.BITS_PER_CYCLE(4)) dut_b (
        .clk        (clk),
        .resetn     (resetn),
        .pcpi_valid (valid_b),
        .pcpi_insn  (insn),
        .pcpi_rs1   (rs1),
        .pcpi_rs2   (rs2),
        .pcpi_wr    (wr_b),
        .pcpi_rd    (rd_b),
        .pcpi_wait  (wait_b),
        .pcpi_ready (ready_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // R-type MULDIV encoding with rd=x3, rs1=x1, rs2=x2
    function automatic logic [31:0] mk(input logic [2:0] f3);
        mk = {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction

    // Issue one request and observe it. Cycle T is the cycle the request is
    // presented; k counts the cycles after it.
    task automatic do_op(input bit sel_b, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input bit keep, output logic [31:0] rd,
                         output int lat, output int wcnt, output logic wr);
        @(negedge clk);
        insn = mk({1'b1, op});
        rs1  = a;
        rs2  = b;
        if (sel_b) valid_b = 1'b1; else valid_a = 1'b1;
        lat  = -1;
        wcnt = 0;
        rd   = 32'hDEADBEEF;
        wr   = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (sel_b ? wait_b : wait_a) wcnt++;
            if (sel_b ? ready_b : ready_a) begin
                lat = k;
                rd  = sel_b ? rd_b : rd_a;
                wr  = sel_b ? wr_b : wr_a;
                break;
            end
        end
        if (!keep) begin
            valid_a = 1'b0;
            valid_b = 1'b0;
        end
    endtask

    task automatic test_reset();
        // Initial reset values
        if ({wr_a, wait_a, ready_a} !== 3'b000 || rd_a !== 32'd0) begin
            errors++;
            $display("FAIL reset_init: wr/wait/ready=%b rd=%h, required 000 / 00000000",
                     {wr_a, wait_a, ready_a}, rd_a);
        end
        checks++;
        // Reset in the middle of a DIV
        @(negedge clk);
        insn = mk(3'b100); rs1 = 32'd1000; rs2 = 32'd3; valid_a = 1'b1;
        repeat (5) @(negedge clk);
        if (wait_a !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_wait: wait=%b, required 1", wait_a);
        end
        checks++;
        #2 resetn = 1'b0;
        #1;
        if ({wr_a, wait_a, ready_a} !== 3'b000 || rd_a !== 32'd0) begin
            errors++;
            $display("FAIL reset_async: wr/wait/ready=%b rd=%h, required 000 / 00000000",
                     {wr_a, wait_a, ready_a}, rd_a);
        end
        checks++;
        valid_a = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        begin
            int nready;
            nready = 0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (ready_a || wr_a || wait_a) nready++;
            end
            if (nready != 0) begin
                errors++;
                $display("FAIL reset_quiet: %0d active cycles, required 0", nready);
            end
            checks++;
        end
    endtask

    task automatic test_signed();
        logic [31:0] rd; int lat, wcnt; logic wr;
        do_op(0, OP_DIV, 32'hFFFFFFF9, 32'h2, 0, rd, lat, wcnt, wr);
        if (rd !== 32'hFFFFFFFD) begin
            errors++; $display("FAIL div_signed: rd=%h, required FFFFFFFD", rd);
        end
        checks++;
        if (lat != 33) begin
            errors++; $display("FAIL div_latency: %0d, required 33", lat);
        end
        checks++;
        if (wcnt != 32) begin
            errors++; $display("FAIL div_wait_cycles: %0d, required 32", wcnt);
        end
        checks++;
        if (wr !== 1'b1) begin
            errors++; $display("FAIL div_wr: wr=%b, required 1", wr);
        end
        checks++;
        // rd cleared in the cycle after ready
        @(negedge clk);
        if (rd_a !== 32'd0 || ready_a !== 1'b0 || wr_a !== 1'b0) begin
            errors++;
            $display("FAIL div_clear: rd=%h ready=%b wr=%b, required 0", rd_a, ready_a, wr_a);
        end
        checks++;
        do_op(0, OP_REM, 32'hFFFFFFF9, 32'h2, 0, rd, lat, wcnt, wr);
        if (rd !== 32'hFFFFFFFF || lat != 33) begin
            errors++; $display("FAIL rem_signed: rd=%h lat=%0d, required FFFFFFFF 33", rd, lat);
        end
        checks++;
    endtask

    task automatic test_unsigned();
        logic [31:0] rd; int lat, wcnt; logic wr;
        do_op(0, OP_DIVU, 32'hFFFFFFFF, 32'h10, 0, rd, lat, wcnt, wr);
        if (rd !== 32'h0FFFFFFF || lat != 33) begin
            errors++; $display("FAIL divu: rd=%h lat=%0d, required 0FFFFFFF 33", rd, lat);
        end
        checks++;
        do_op(0, OP_REMU, 32'hFFFFFFFF, 32'h10, 0, rd, lat, wcnt, wr);
        if (rd !== 32'h0000000F || lat != 33) begin
            errors++; $display("FAIL remu: rd=%h lat=%0d, required 0000000F 33", rd, lat);
        end
        checks++;
        do_op(1, OP_DIVU, 32'hFFFFFFFF, 32'h10, 0, rd, lat, wcnt, wr);
        if (rd !== 32'h0FFFFFFF || lat != 9 || wcnt != 8) begin
            errors++;
            $display("FAIL divu_b4: rd=%h lat=%0d wait=%0d, required 0FFFFFFF 9 8", rd, lat, wcnt);
        end
        checks++;
        do_op(1, OP_REMU, 32'hFFFFFFFF, 32'h10, 0, rd, lat, wcnt, wr);
        if (rd !== 32'h0000000F || lat != 9) begin
            errors++; $display("FAIL remu_b4: rd=%h lat=%0d, required 0000000F 9", rd, lat);
        end
        checks++;
        do_op(1, OP_DIV, 32'hFFFFFFF9, 32'h2, 0, rd, lat, wcnt, wr);
        if (rd !== 32'hFFFFFFFD || lat != 9) begin
            errors++; $display("FAIL div_b4: rd=%h lat=%0d, required FFFFFFFD 9", rd, lat);
        end
        checks++;
    endtask

    task automatic test_div_zero();
        logic [31:0] rd; int lat, wcnt; logic wr;
        logic [1:0]  ops [4];
        logic [31:0] exp [4];
        ops = '{OP_DIV, OP_DIVU, OP_REM, OP_REMU};
        exp = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678, 32'h12345678};
        for (int i = 0; i < 4; i++) begin
            do_op(0, ops[i], 32'h12345678, 32'h0, 0, rd, lat, wcnt, wr);
            if (rd !== exp[i] || lat != 33) begin
                errors++;
                $display("FAIL div_zero op%0d: rd=%h lat=%0d, required %h 33", i, rd, lat, exp[i]);
            end
            checks++;
        end
        // Negative dividend by zero: REM returns rs1 unchanged
        do_op(0, OP_REM, 32'hFFFFFFF9, 32'h0, 0, rd, lat, wcnt, wr);
        if (rd !== 32'hFFFFFFF9) begin
            errors++; $display("FAIL rem_zero_neg: rd=%h, required FFFFFFF9", rd);
        end
        checks++;
    endtask

    task automatic test_overflow();
        logic [31:0] rd; int lat, wcnt; logic wr;
        do_op(0, OP_DIV, 32'h80000000, 32'hFFFFFFFF, 0, rd, lat, wcnt, wr);
        if (rd !== 32'h80000000 || lat != 33) begin
            errors++; $display("FAIL ovf_div: rd=%h lat=%0d, required 80000000 33", rd, lat);
        end
        checks++;
        do_op(0, OP_REM, 32'h80000000, 32'hFFFFFFFF, 0, rd, lat, wcnt, wr);
        if (rd !== 32'h00000000 || lat != 33) begin
            errors++; $display("FAIL ovf_rem: rd=%h lat=%0d, required 00000000 33", rd, lat);
        end
        checks++;
    endtask

    task automatic test_nonmatch_abort();
        int active;
        logic [31:0] rd; int lat, wcnt; logic wr;
        // MUL (funct3 000) must be ignored
        @(negedge clk);
        insn = mk(3'b000); rs1 = 32'd6; rs2 = 32'd7; valid_a = 1'b1;
        active = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (wait_a || ready_a || wr_a || rd_a != 32'd0) active++;
        end
        valid_a = 1'b0;
        if (active != 0) begin
            errors++; $display("FAIL nonmatch: %0d active cycles, required 0", active);
        end
        checks++;
        // DIV aborted at T+10
        @(negedge clk);
        insn = mk(3'b100); rs1 = 32'd100; rs2 = 32'd7; valid_a = 1'b1;
        repeat (10) @(negedge clk);
        if (wait_a !== 1'b1) begin
            errors++; $display("FAIL abort_pre_wait: wait=%b, required 1", wait_a);
        end
        checks++;
        valid_a = 1'b0;
        @(negedge clk);
        if (wait_a !== 1'b0) begin
            errors++; $display("FAIL abort_wait: wait=%b at T+11, required 0", wait_a);
        end
        checks++;
        active = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (wr_a || ready_a || wait_a) active++;
        end
        if (active != 0) begin
            errors++; $display("FAIL abort_nowr: %0d active cycles, required 0", active);
        end
        checks++;
        do_op(0, OP_DIV, 32'd100, 32'd7, 0, rd, lat, wcnt, wr);
        if (rd !== 32'd14 || lat != 33) begin
            errors++; $display("FAIL after_abort: rd=%h lat=%0d, required 0000000E 33", rd, lat);
        end
        checks++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; int lat, wcnt; logic wr;
        do_op(0, OP_DIVU, 32'd1000, 32'd10, 1, rd, lat, wcnt, wr);
        if (rd !== 32'd100 || lat != 33) begin
            errors++; $display("FAIL b2b_first: rd=%h lat=%0d, required 00000064 33", rd, lat);
        end
        checks++;
        // Valid still high in the DONE cycle: must not be accepted there
        @(negedge clk);
        if (rd_a !== 32'd0 || ready_a !== 1'b0 || wait_a !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap: rd=%h ready=%b wait=%b, required 0", rd_a, ready_a, wait_a);
        end
        checks++;
        // Second request presented at T+N+2; sampling later operand changes
        // is also checked by altering rs1 mid-operation
        insn = mk(3'b111); rs1 = 32'd1000; rs2 = 32'd7;
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 3) begin rs1 = 32'd5; rs2 = 32'd2; insn = mk(3'b101); end
            if (ready_a) begin lat = k; rd = rd_a; break; end
        end
        valid_a = 1'b0;
        if (rd !== 32'd6 || lat != 33) begin
            errors++; $display("FAIL b2b_second: rd=%h lat=%0d, required 00000006 33", rd, lat);
        end
        checks++;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        resetn  = 1'b1;
        valid_a = 1'b0;
        valid_b = 1'b0;
        insn    = 32'd0;
        rs1     = 32'd0;
        rs2     = 32'd0;
        #3 resetn = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        test_reset();
        test_signed();
        test_unsigned();
        test_div_zero();
        test_overflow();
        test_nonmatch_abort();
        test_back_to_back();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pcpi_seq_div.md
# pcpi_seq_div

Iterative RV32M divide/remainder coprocessor on the PCPI bus. Decodes DIV, DIVU, REM and REMU from the core's `pcpi_insn`, runs a restoring shift-subtract divider over multiple cycles, and returns one result word through the `pcpi_wr`/`pcpi_ready` handshake. It sits between the core's PCPI master and the `pcpi_div_if` protocol checker, which monitors its outputs.

## Interface
- `BITS_PER_CYCLE`, default 1: quotient bits resolved per BUSY cycle. Legal values are 1, 2 and 4. BUSY length N = 32 / `BITS_PER_CYCLE`.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `pcpi_valid` in 1: core presents an instruction.
- `pcpi_insn` in 32: instruction word.
- `pcpi_rs1` in 32: dividend.
- `pcpi_rs2` in 32: divisor.
- `pcpi_wr` out 1: result write enable. Asserted only together with `pcpi_ready`.
- `pcpi_rd` out 32: result word.
- `pcpi_wait` out 1: request accepted, computation in progress.
- `pcpi_ready` out 1: result valid, one-cycle pulse.

## Operation
- **Match:** `insn[6:0]`=0110011, `insn[31:25]`=0000001, `insn[14]`=1.
  - `insn[13:12]` selects the operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
  - Any other instruction is ignored: all outputs stay 0.
- **FSM states:** IDLE, BUSY, DONE.
- **IDLE → BUSY** when `pcpi_valid` is high and the instruction matches. On that edge, latch:
  - the operation;
  - `dividend` = |rs1| and `divisor` = |rs2|, each taken as absolute value when signed (DIV/REM) and raw when unsigned;
  - `q_neg` = rs1[31]^rs2[31] for DIV;
  - `r_neg` = rs1[31] for REM;
  - `div0` = (rs2==0);
  - iteration counter loaded with N-1.
- **BUSY:** each cycle performs `BITS_PER_CYCLE` restoring steps.
  - Partial remainder is 33 bits; shift in the next dividend bit.
  - If the trial subtract is non-negative, keep it and set the quotient bit to 1. Otherwise restore.
  - Counter decrements each cycle. At 0 go to DONE and register the result.
- **Result selection:**
  - DIV/DIVU: quotient, negated if `q_neg` and not `div0`.
  - REM/REMU: remainder, negated if `r_neg`.
- **Arithmetic rules:**
  - All negation is 32-bit two's complement, and |x| is computed in 32 bits unsigned, so |0x80000000| = 0x80000000.
  - Divide by zero gives: DIV = 0xFFFFFFFF, DIVU = 0xFFFFFFFF, REM = rs1, REMU = rs1.
  - Overflow (0x80000000 / 0xFFFFFFFF) gives: DIV = 0x80000000, REM = 0.
  - Both special cases fall out of the datapath. No special-case bypass, so latency is uniform.
- **DONE:** `pcpi_ready`=`pcpi_wr`=1 for exactly one cycle with `pcpi_rd` stable, then return to IDLE.
- **Abort:** `pcpi_valid` low in any BUSY cycle → IDLE next edge. Outputs clear, no write, partial state discarded.
- **Reset mid-operation:** immediate return to IDLE with all outputs 0. No write is produced for the interrupted request.

## Timing
- **Reset values:** `pcpi_wr`=0, `pcpi_rd`=0, `pcpi_wait`=0, `pcpi_ready`=0, FSM=IDLE. All outputs are registered.
- **Cycle numbering:** accept cycle T, where `pcpi_valid` is high and the instruction matches.
- **`pcpi_wait`:** high in cycles T+1 .. T+N.
- **`pcpi_ready`/`pcpi_wr`:** high in cycle T+N+1 only. Latency is 33 cycles at `BITS_PER_CYCLE`=1, 17 at 2, 9 at 4.
- **`pcpi_rd`:** holds the result from T+N+1. Cleared to 0 in the following cycle.
- **Operand sampling:** `pcpi_insn`, `pcpi_rs1` and `pcpi_rs2` are sampled only at T. Later changes while valid stays high have no effect.
- **Master contract:** the master drops `pcpi_valid` in the cycle after `pcpi_ready`. The block does not accept a request in the DONE cycle, and IDLE may accept again at T+N+2.
- **Back-to-back:** valid re-asserted at T+N+2 with a new matching instruction starts a new operation with the same latency.
- **Simultaneous valid drop and final BUSY cycle:** abort wins; no ready is produced.

## Test plan
- **Reset:** assert `resetn`=0 mid-BUSY. All outputs 0 asynchronously; after release, IDLE and no `pcpi_ready` for 40 cycles.
- **DIV/REM signed** (B=1), rs1=0xFFFFFFF9 (-7), rs2=0x00000002:
  - DIV gives `pcpi_rd`=0xFFFFFFFD at T+33 with `wr`=`ready`=1.
  - REM gives 0xFFFFFFFF.
  - `wait` is high T+1..T+32.
- **DIVU/REMU:** rs1=0xFFFFFFFF, rs2=0x00000010 gives DIVU=0x0FFFFFFF and REMU=0x0000000F. Repeat with B=4: ready at T+9, same values.
- **Divide by zero:** rs1=0x12345678, rs2=0 gives DIV=0xFFFFFFFF, DIVU=0xFFFFFFFF, REM=0x12345678, REMU=0x12345678.
- **Overflow:** rs1=0x80000000, rs2=0xFFFFFFFF gives DIV=0x80000000 and REM=0x00000000.
- **Non-match and abort:**
  - MUL instruction (`insn[14:12]`=000) gives no `wait`/`ready` for 40 cycles.
  - DIV with valid dropped at T+10 gives `wait` low at T+11 and no `wr`.
  - The next DIV 100/7 returns 14 with normal latency.
